ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

PS/2 device-to-host frame receiver that decodes the 11-bit serial frames from the keyboard port into scan-code bytes and buffers them in a small FIFO. Sits directly upstream of the keyboard scan-code tracker: it feeds it `data`/`ready`/`overflow` and is drained through the active-low `nextdata_n` handshake. Adds frame validation (start, parity, stop), a stale-frame timeout and error reporting.

## Interface
- `DEPTH_LOG2`, 3, FIFO depth = 2^DEPTH_LOG2 entries (8).
- `TIMEOUT`, 100000, idle clk cycles mid-frame before the partial frame is discarded (2 ms at 50 MHz).
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous to `clk`.
- `nextdata_n` in 1: active-low read acknowledge; pop happens on the edge where `ready`=1 and `nextdata_n`=0.
- `data` out 8: FIFO head byte; valid whenever `ready`=1.
- `ready` out 1: FIFO not empty.
- `overflow` out 1: sticky; a valid frame arrived while the FIFO was full.
- `frame_err` out 1: one-cycle pulse on a rejected frame (bad start/parity/stop or timeout).
- `err_count` out 8: saturating count of rejected frames.

## Operation
- Synchronizer: 3-stage shift register on `ps2_clk`, 2-stage on `ps2_data`. A falling edge is sampled when `ps2_clk` stages [2:1] = 2'b10; the synchronized data bit is sampled in that same cycle.
- Frame FSM states are IDLE, SHIFT and CHECK, with a 4-bit bit counter.
  - IDLE: on a falling edge, capture the start bit and go to SHIFT with count = 1.
  - SHIFT: each falling edge shifts one bit into an 10-bit register (LSB-first data, then parity, then stop). After bit 10, go to CHECK.
  - CHECK: one cycle. The frame is valid when start = 0, stop = 1, and the XOR of data[7:0] and parity = 1 (odd parity).
    - Valid and FIFO not full: write the byte.
    - Valid and FIFO full: drop the byte and set `overflow`.
    - Invalid: pulse `frame_err` and increment `err_count`, saturating at 255.
  - CHECK always returns to IDLE.
- Timeout:
  - A 17-bit counter clears on every falling edge and increments in SHIFT.
  - Reaching TIMEOUT−1 forces IDLE, counts as a rejected frame and pulses `frame_err`.
  - The counter is held at 0 in IDLE.
- FIFO:
  - 8×8 register array with DEPTH_LOG2+1-bit read and write pointers.
  - Full when the pointer MSBs differ and the low bits are equal; empty when the pointers are equal.
  - `data` = mem[rptr low bits], read combinationally.
- Pop: on the edge where `ready`=1 and `nextdata_n`=0, increment `rptr`. A pop while empty is ignored.
- `overflow` clears on the first pop after it was set. A pop and a set in the same cycle leave it set.
- Simultaneous write and pop:
  - Both take effect.
  - With the FIFO full, the pop frees no slot in time; the frame is dropped and `overflow` is set.
  - With the FIFO empty, the write lands and `ready` rises next cycle; the pop is ignored.

## Timing
- Reset values: `ready`=0, `data`=mem[0] (memory is not reset; don't-care while `ready`=0), `overflow`=0, `frame_err`=0, `err_count`=0. FSM goes to IDLE, pointers and timeout counter to 0.
- `rst` asserted mid-frame: the partial frame is lost and the FIFO is flushed; no error is counted.
- Edge detect latency: 3 clk cycles from the raw `ps2_clk` fall to the sample cycle.
- Stop bit sampled at cycle E: CHECK runs at E+1, and `ready`/`data` are valid at E+2.
- `frame_err` is high for exactly the CHECK cycle, or the timeout cycle.
- Back-to-back pops are allowed every cycle while `nextdata_n`=0.

## Test plan
- Reset then send frame 0x1C (parity 0, stop 1) → `ready`=1 and `data`=8'h1C two cycles after the stop sample. With `nextdata_n`=0 for one edge → `ready`=0 and `err_count`=0.
- Send 0xE0, 0xF0, 0x75 with `nextdata_n` held at 1 → `ready` stays 1. Pulsing `nextdata_n` low three times yields 8'hE0, 8'hF0, 8'h75 in order, then `ready`=0.
- Send 9 valid frames with no pops → the first 8 are stored and `overflow`=1 after the 9th. One pop returns the first byte and clears `overflow`; the remaining 7 are intact.
- Send 0x1C with a wrong parity bit, then one with stop = 0 → `frame_err` pulses twice, `err_count`=2, `ready`=0.
- Send 5 bits, then idle ≥ TIMEOUT cycles → one `frame_err` pulse and `err_count`=1. A following valid 0x29 is received correctly.
- Assert `rst` after 6 bits of a frame with 3 bytes queued → all outputs return to reset values. A following valid frame 0x5A is received as the sole FIFO entry.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver: synchronizes the keyboard pins, validates
// 11-bit frames (start/parity/stop, stale-frame timeout) and queues bytes in a FIFO.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [16:0] TO_LAST = 17'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t                r_state, w_stateNext;
  logic [2:0]            r_clkSync;
  logic [1:0]            r_dataSync;
  logic [3:0]            r_bitCnt, w_bitCntNext;
  logic [9:0]            r_shift, w_shiftNext;
  logic                  r_start, w_startNext;
  logic [16:0]           r_toCnt, w_toCntNext;
  logic [7:0]            r_mem [0:DEPTH-1];
  logic [DEPTH_LOG2:0]   r_wptr, r_rptr;
  logic [7:0]            r_errCount;
  logic                  r_overflow;
  logic                  w_fall, w_bit, w_valid, w_full, w_empty;
  logic                  w_push, w_drop, w_pop, w_reject;

  // Idle PS/2 lines are high, so the synchronizers reset to ones to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clkSync  <= 3'b111;
      r_dataSync <= 2'b11;
    end else begin
      r_clkSync  <= {r_clkSync[1:0], ps2_clk};
      r_dataSync <= {r_dataSync[0], ps2_data};
    end
  end

  assign w_fall  = (r_clkSync[2:1] == 2'b10);
  assign w_bit   = r_dataSync[1];
  // Shift register holds data[7:0], parity, stop; odd parity over data plus parity.
  assign w_valid = !r_start && r_shift[9] && (^r_shift[8:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                   (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
  assign w_pop   = !w_empty && !nextdata_n;

  always_comb begin
    w_stateNext  = r_state;
    w_bitCntNext = r_bitCnt;
    w_shiftNext  = r_shift;
    w_startNext  = r_start;
    w_toCntNext  = r_toCnt;
    w_push       = 1'b0;
    w_drop       = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      IDLE: begin
        w_toCntNext = '0;
        if (w_fall) begin
          w_startNext  = w_bit;
          w_bitCntNext = 4'd1;
          w_stateNext  = SHIFT;
        end
      end
      SHIFT: begin
        if (w_fall) begin
          w_shiftNext  = {w_bit, r_shift[9:1]};
          w_toCntNext  = '0;
          w_bitCntNext = r_bitCnt + 4'd1;
          if (r_bitCnt == 4'd10) w_stateNext = CHECK;
        end else if (r_toCnt == TO_LAST) begin
          w_reject    = 1'b1;
          w_toCntNext = '0;
          w_stateNext = IDLE;
        end else begin
          w_toCntNext = r_toCnt + 17'd1;
        end
      end
      CHECK: begin
        w_stateNext = IDLE;
        w_toCntNext = '0;
        if (!w_valid)    w_reject = 1'b1;
        else if (w_full) w_drop   = 1'b1;
        else             w_push   = 1'b1;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_start    <= 1'b0;
      r_toCnt    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_errCount <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_bitCnt <= w_bitCntNext;
      r_shift  <= w_shiftNext;
      r_start  <= w_startNext;
      r_toCnt  <= w_toCntNext;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_reject && r_errCount != 8'hFF) r_errCount <= r_errCount + 8'd1;
      // A drop in the same cycle as a pop wins, so overflow stays set.
      if (w_drop)     r_overflow <= 1'b1;
      else if (w_pop) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= r_shift[7:0];
  end

  assign data      = r_mem[r_rptr[DEPTH_LOG2-1:0]];
  assign ready     = !w_empty;
  assign overflow  = r_overflow;
  assign frame_err = w_reject;
  assign err_count = r_errCount;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed self-checking bench for ps2_rx_fifo: drives PS/2 frames bit by bit
// and compares outputs against hand-computed bytes, flags and counts.
module tb_ps2_rx_fifo;

  localparam int TB_TIMEOUT = 200;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;
  logic [7:0] err_count;

  int checkCount;
  int passCount;
  int errPulses;

  ps2_rx_fifo #(.DEPTH_LOG2(3), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .nextdata_n(nextdata_n),
    .data(data),
    .ready(ready),
    .overflow(overflow),
    .frame_err(frame_err),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_err pulses away from the active edge; each pulse lasts one cycle.
  always @(negedge clk) begin
    if (!rst && frame_err) errPulses <= errPulses + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One PS/2 bit: data set up, clock low for 8 cycles, then high again.
  task automatic applyStimulus(input logic b);
    ps2_data = b;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (8) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] b, input logic goodParity, input logic stopBit);
    logic par;
    par = goodParity ? ~(^b) : (^b);
    return {stopBit, par, b, 1'b0};
  endfunction

  task automatic sendBits(input logic [10:0] frame, input int nBits);
    for (int i = 0; i < nBits; i++) applyStimulus(frame[i]);
  endtask

  task automatic sendFrame(input logic [7:0] b);
    sendBits(makeFrame(b, 1'b1, 1'b1), 11);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic popOne();
    nextdata_n = 1'b0;
    @(posedge clk); #1;
    nextdata_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int pulsesBefore;

  initial begin
    checkCount = 0;
    passCount  = 0;
    errPulses  = 0;
    rst        = 1'b0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;

    // Reset values and exact latency of the first frame (0x1C).
    applyReset();
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_err_count", err_count, 0);
    sendBits(makeFrame(8'h1C, 1'b1, 1'b1), 10);
    ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkOutput("lat_check_ready", ready, 0);
    checkOutput("lat_check_err", frame_err, 0);
    @(posedge clk); #1;
    checkOutput("lat_ready", ready, 1);
    checkOutput("lat_data", data, 8'h1C);
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1 popOne();
    checkOutput("pop1_ready", ready, 0);
    checkOutput("pop1_err_count", err_count, 0);

    // Three queued frames read back in order.
    sendFrame(8'hE0);
    sendFrame(8'hF0);
    sendFrame(8'h75);
    checkOutput("q3_ready", ready, 1);
    checkOutput("q3_data0", data, 8'hE0);
    popOne();
    checkOutput("q3_data1", data, 8'hF0);
    popOne();
    checkOutput("q3_data2", data, 8'h75);
    popOne();
    checkOutput("q3_empty", ready, 0);

    // Nine frames into an 8-deep FIFO: the ninth is dropped and flags overflow.
    for (int i = 0; i < 8; i++) sendFrame(8'(8'h10 + i));
    checkOutput("ovf_before", overflow, 0);
    sendFrame(8'h99);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_head", data, 8'h10);
    popOne();
    checkOutput("ovf_clear", overflow, 0);
    for (int i = 1; i < 8; i++) begin
      checkOutput($sformatf("ovf_data%0d", i), data, 32'(8'h10 + i));
      popOne();
    end
    checkOutput("ovf_empty", ready, 0);

    // Bad parity, then bad stop bit.
    applyReset();
    pulsesBefore = errPulses;
    sendBits(makeFrame(8'h1C, 1'b0, 1'b1), 11);
    repeat (3) @(posedge clk);
    #1 sendBits(makeFrame(8'h1C, 1'b1, 1'b0), 11);
    repeat (3) @(posedge clk);
    #1;
    ps2_data = 1'b1;
    checkOutput("bad_pulses", errPulses - pulsesBefore, 2);
    checkOutput("bad_err_count", err_count, 2);
    checkOutput("bad_ready", ready, 0);

    // Stale partial frame times out, then a clean frame is received.
    applyReset();
    pulsesBefore = errPulses;
    sendBits(makeFrame(8'h29, 1'b1, 1'b1), 5);
    repeat (TB_TIMEOUT + 50) @(posedge clk);
    #1 checkOutput("to_pulses", errPulses - pulsesBefore, 1);
    checkOutput("to_err_count", err_count, 1);
    checkOutput("to_ready", ready, 0);
    sendFrame(8'h29);
    checkOutput("to_after_ready", ready, 1);
    checkOutput("to_after_data", data, 8'h29);
    checkOutput("to_after_err_count", err_count, 1);

    // Reset mid-frame with bytes queued flushes everything.
    applyReset();
    sendFrame(8'h11);
    sendFrame(8'h22);
    sendFrame(8'h33);
    checkOutput("mid_queued", ready, 1);
    pulsesBefore = errPulses;
    sendBits(makeFrame(8'h44, 1'b1, 1'b1), 6);
    rst = 1'b1;
    #1 checkOutput("mid_rst_ready", ready, 0);
    checkOutput("mid_rst_overflow", overflow, 0);
    checkOutput("mid_rst_err_count", err_count, 0);
    checkOutput("mid_rst_frame_err", frame_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    sendFrame(8'h5A);
    checkOutput("mid_after_ready", ready, 1);
    checkOutput("mid_after_data", data, 8'h5A);
    popOne();
    checkOutput("mid_after_sole", ready, 0);
    checkOutput("mid_no_err", errPulses - pulsesBefore, 0);
    checkOutput("mid_err_count", err_count, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
